mux_rr_arbiter: RTL and testbench

//   Shares one 4:1 data mux between four requesters using round-robin arbitration.

---
 rtl/mux_rr_arbiter_pkg.sv | 20 ++
 rtl/mux_rr_arbiter_if.sv | 28 ++
 rtl/mux_rr_arbiter_rr_pick.sv | 29 ++
 rtl/mux_rr_arbiter.sv | 71 +++++++
 tb/tb_mux_rr_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the four-way round-robin mux arbiter.
package mux_arb_pkg;

   localparam int N_REQ = 4;

   typedef logic [1:0] req_idx_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } arb_state_t;

   function automatic logic [N_REQ-1:0] onehot(req_idx_t i);
      logic [N_REQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester bundle plus the downstream valid/ready channel of the arbiter.
interface mux_rr_arbiter_if #(
   parameter int W = 4
);
   import mux_arb_pkg::*;

   logic [N_REQ-1:0] req;
   logic [W-1:0]     d0;
   logic [W-1:0]     d1;
   logic [W-1:0]     d2;
   logic [W-1:0]     d3;
   logic [N_REQ-1:0] gnt;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_data;
   req_idx_t         out_sel;

   modport master (
      output req, d0, d1, d2, d3, out_ready,
      input  gnt, out_valid, out_data, out_sel
   );

   modport slave (
      input  req, d0, d1, d2, d3, out_ready,
      output gnt, out_valid, out_data, out_sel
   );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate so last+1 is bit 0, priority-encode, un-rotate.
module rr_pick
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  req_idx_t         last,
   output req_idx_t         winner,
   output logic             any
);

   req_idx_t         off;
   req_idx_t         pick;
   logic [N_REQ-1:0] rot;

   always_comb begin
      off  = last + 2'd1;
      rot  = '0;
      pick = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         rot[k] = req[off + req_idx_t'(k)];
      end
      for (int unsigned k = N_REQ; k > 0; k--) begin
         if (rot[k-1]) pick = req_idx_t'(k-1);
      end
      winner = off + pick;
      any    = |req;
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux; the winner's word is registered
// and offered downstream on a valid/ready handshake.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int W = 4
) (
   input logic              clk,
   input logic              rst,
   mux_rr_arbiter_if.slave  bus
);

   arb_state_t state, state_nxt;
   req_idx_t   last;
   req_idx_t   winner;
   logic       any;
   logic       load;
   logic [W-1:0] mux_data;

   rr_pick u_pick (
      .req    (bus.req),
      .last   (last),
      .winner (winner),
      .any    (any)
   );

   always_comb begin
      mux_data = bus.d0;
      unique case (winner)
         2'd0: mux_data = bus.d0;
         2'd1: mux_data = bus.d1;
         2'd2: mux_data = bus.d2;
         2'd3: mux_data = bus.d3;
         default: mux_data = bus.d0;
      endcase
   end

   // A full register may be refilled on the same edge it is drained.
   always_comb begin
      load      = any && ((state == EMPTY) || bus.out_ready);
      state_nxt = state;
      if (load)
         state_nxt = FULL;
      else if ((state == FULL) && bus.out_ready)
         state_nxt = EMPTY;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_data <= '0;
         bus.out_sel  <= '0;
         bus.gnt      <= '0;
         last         <= 2'd3;
      end else begin
         bus.gnt <= load ? onehot(winner) : '0;
         if (load) begin
            bus.out_data <= mux_data;
            bus.out_sel  <= winner;
            last         <= winner;
         end
      end
   end

   assign bus.out_valid = (state == FULL);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed plus randomized checks of mux_rr_arbiter against a scan-based reference model.
module tb_mux_rr_arbiter;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [W-1:0] dv [4];

   always #5 clk = ~clk;

   mux_rr_arbiter_if #(.W(W)) bus ();

   mux_rr_arbiter #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.d0 = dv[0];
   assign bus.d1 = dv[1];
   assign bus.d2 = dv[2];
   assign bus.d3 = dv[3];

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state
   int         m_last  = 3;
   logic       m_valid = 1'b0;
   logic [W-1:0] m_data = '0;
   int         m_sel   = 0;
   logic [3:0] m_gnt   = '0;

   typedef struct { int sel; logic [W-1:0] data; } word_t;
   word_t sb [$];

   logic [3:0]   pre_req;
   logic         pre_hold;
   logic [W-1:0] pre_data;
   int           pre_sel;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int scan(input logic [3:0] r, input int lst);
      for (int j = 1; j <= 4; j++) begin
         if (r[(lst + j) % 4]) return (lst + j) % 4;
      end
      return -1;
   endfunction

   // Advance the model over one edge, then compare the DUT just after the edge.
   task automatic step();
      int w;
      word_t e;
      pre_req  = bus.req;
      pre_hold = !rst && m_valid && !bus.out_ready;
      pre_data = m_data;
      pre_sel  = m_sel;
      if (rst) begin
         m_valid = 1'b0; m_data = '0; m_sel = 0; m_last = 3; m_gnt = '0;
         sb.delete();
      end else begin
         if (m_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               check("sb_empty_on_accept", 32'(sb.size()), 32'd1);
            end else begin
               e = sb.pop_front();
               check("sb_data", 32'(bus.out_data), 32'(e.data));
               check("sb_sel",  32'(bus.out_sel),  32'(e.sel));
            end
         end
         w = scan(bus.req, m_last);
         if (w >= 0 && (!m_valid || bus.out_ready)) begin
            m_data  = dv[w];
            m_sel   = w;
            m_last  = w;
            m_valid = 1'b1;
            m_gnt   = 4'(1 << w);
            e.sel = w; e.data = dv[w];
            sb.push_back(e);
         end else begin
            m_gnt = '0;
            if (m_valid && bus.out_ready) m_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      check("out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("out_data",  32'(bus.out_data),  32'(m_data));
      check("out_sel",   32'(bus.out_sel),   32'(m_sel));
      check("gnt",       32'(bus.gnt),       32'(m_gnt));
      check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      if (!rst) check("gnt_implies_req", 32'(bus.gnt & ~pre_req), 32'd0);
      if (pre_hold) begin
         check("hold_valid", 32'(bus.out_valid), 32'd1);
         check("hold_data",  32'(bus.out_data),  32'(pre_data));
         check("hold_sel",   32'(bus.out_sel),   32'(pre_sel));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      bus.req = '0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) dv[i] = '0;

      // 1: reset state
      do_reset();
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_gnt",   32'(bus.gnt),       32'd0);
      check("rst_data",  32'(bus.out_data),  32'd0);
      check("rst_sel",   32'(bus.out_sel),   32'd0);
      step();
      check("idle_valid", 32'(bus.out_valid), 32'd0);

      // 2: single requester 2
      bus.req = 4'b0100; dv[2] = 4'hA; bus.out_ready = 1'b1;
      step();
      check("t2_gnt",  32'(bus.gnt),       32'h4);
      check("t2_data", 32'(bus.out_data),  32'hA);
      check("t2_sel",  32'(bus.out_sel),   32'd2);
      check("t2_vld",  32'(bus.out_valid), 32'd1);
      bus.req = '0;
      step();

      // 3: all requesting, back-to-back rotation
      do_reset();
      for (int i = 0; i < 4; i++) dv[i] = 4'(i + 1);
      bus.req = 4'b1111; bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t3_sel",  32'(bus.out_sel),   32'(i % 4));
         check("t3_data", 32'(bus.out_data),  32'((i % 4) + 1));
         check("t3_vld",  32'(bus.out_valid), 32'd1);
      end
      bus.req = '0;
      step();

      // 4: backpressure holds the word
      do_reset();
      dv[0] = 4'h5; dv[1] = 4'h6;
      bus.req = 4'b0011; bus.out_ready = 1'b0;
      step();
      check("t4_first_sel", 32'(bus.out_sel), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t4_hold_sel",  32'(bus.out_sel),  32'd0);
         check("t4_hold_data", 32'(bus.out_data), 32'h5);
         check("t4_hold_gnt",  32'(bus.gnt),      32'd0);
      end
      bus.out_ready = 1'b1;
      step();
      check("t4_next_sel", 32'(bus.out_sel), 32'd1);
      bus.req = '0;
      step();

      // 5: wrap-around from last=3
      do_reset();
      dv[0] = 4'h1; dv[3] = 4'hC;
      bus.req = 4'b1001; bus.out_ready = 1'b1;
      step();
      check("t5_first", 32'(bus.out_sel), 32'd0);
      step();
      check("t5_wrap", 32'(bus.out_sel), 32'd3);
      step();
      check("t5_back", 32'(bus.out_sel), 32'd0);
      bus.req = '0;
      step();

      // 6: reset while full and stalled
      bus.req = 4'b0010; dv[1] = 4'h7; bus.out_ready = 1'b0;
      step();
      step();
      bus.req = '0;
      rst = 1'b1;
      step();
      check("t6_rst_vld", 32'(bus.out_valid), 32'd0);
      rst = 1'b0;
      bus.req = 4'b1000; dv[3] = 4'h9; bus.out_ready = 1'b1;
      step();
      check("t6_sel",  32'(bus.out_sel),  32'd3);
      check("t6_data", 32'(bus.out_data), 32'h9);
      bus.req = '0;
      step();

      // randomized traffic
      do_reset();
      for (int i = 0; i < 400; i++) begin
         bus.req = 4'($urandom_range(0, 15));
         for (int k = 0; k < 4; k++) dv[k] = W'($urandom);
         bus.out_ready = ($urandom % 4) != 0;
         rst = ($urandom % 64) == 0;
         step();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
